// File: rtl/md_sched.sv
// HI/LO multiply/divide unit: captures the result when the op starts, counts out
// the busy time, commits HI/LO at the end, and drives the ID-stage stall for MD ops.
module md_sched #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        id_md,
   output logic        busy,
   output logic        id_stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [0:0] StIdle = 1'b0;
   localparam logic [0:0] StRun  = 1'b1;

   localparam logic [3:0] OpMult  = 4'd1;
   localparam logic [3:0] OpMultu = 4'd2;
   localparam logic [3:0] OpDiv   = 4'd3;
   localparam logic [3:0] OpDivu  = 4'd4;
   localparam logic [3:0] OpMadd  = 4'd5;
   localparam logic [3:0] OpMthi  = 4'd6;
   localparam logic [3:0] OpMtlo  = 4'd7;

   localparam logic [3:0] MultLatM1 = 4'(MULT_CYCLES - 1);
   localparam logic [3:0] DivLatM1  = 4'(DIV_CYCLES - 1);

   logic [0:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] pend_hi_q, pend_hi_d;
   logic [31:0] pend_lo_q, pend_lo_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic        launch;
   logic [3:0]  lat_m1;
   logic [63:0] result;
   logic [63:0] smul;
   logic [63:0] umul;
   logic        div_zero;
   logic        div_ovf;
   logic [31:0] div_b;
   logic signed [31:0] sa, sb, sq, sr;
   logic [31:0] uq, ur;

   // Both products computed at 64 bits; sign-extending the operands gives the signed
   // product modulo 2^64.
   assign smul = {{32{a[31]}}, a} * {{32{b[31]}}, b};
   assign umul = {32'd0, a} * {32'd0, b};

   // Divide-by-zero and MIN/-1 are resolved separately; the divider sees a safe divisor.
   assign div_zero = (b == 32'd0);
   assign div_ovf  = (op == OpDiv) && (a == 32'h8000_0000) && (b == 32'hffff_ffff);
   assign div_b    = (div_zero || div_ovf) ? 32'd1 : b;
   assign sa = a;
   assign sb = div_b;
   assign sq = sa / sb;
   assign sr = sa % sb;
   assign uq = a / div_b;
   assign ur = a % div_b;

   // Decode the EX op: whether it launches a multi-cycle run, its latency and its result.
   always_comb begin
      launch = 1'b0;
      lat_m1 = MultLatM1;
      result = {hi_q, lo_q};
      case (op)
         OpMult: begin
            launch = 1'b1;
            result = smul;
         end
         OpMultu: begin
            launch = 1'b1;
            result = umul;
         end
         OpMadd: begin
            launch = 1'b1;
            result = {hi_q, lo_q} + smul;
         end
         OpDiv: begin
            launch = 1'b1;
            lat_m1 = DivLatM1;
            if (div_zero)     result = {hi_q, lo_q};
            else if (div_ovf) result = {32'd0, 32'h8000_0000};
            else              result = {sr, sq};
         end
         OpDivu: begin
            launch = 1'b1;
            lat_m1 = DivLatM1;
            if (div_zero) result = {hi_q, lo_q};
            else          result = {ur, uq};
         end
         default: ;
      endcase
   end

   // Next-state: start ops from IDLE, count down in RUN, commit on the final edge.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               if (launch) begin
                  {pend_hi_d, pend_lo_d} = result;
                  cnt_d   = lat_m1;
                  state_d = StRun;
               end else if (op == OpMthi) begin
                  hi_d = a;
               end else if (op == OpMtlo) begin
                  lo_d = a;
               end
            end
         end
         default: begin
            // A start here is a pipeline bug and is deliberately ignored.
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               hi_d    = pend_hi_q;
               lo_d    = pend_lo_q;
               state_d = StIdle;
            end
         end
      endcase
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         cnt_q     <= 4'd0;
         pend_hi_q <= 32'd0;
         pend_lo_q <= 32'd0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign busy = (state_q == StRun);
   // Also stalls on the cycle the EX op is launching, before busy has risen.
   assign id_stall = id_md & (busy | (start & launch));
   assign hi = hi_q;
   assign lo = lo_q;

endmodule
